// File: rtl/gray_frame_ctrl.sv
// gray_frame_ctrl: raster RGB reader feeding an external grayscale
// converter, buffering results in a small FIFO for the Sobel stage.
module gray_frame_ctrl #(
  parameter int W_BITS     = 10,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [W_BITS-1:0] width_i,
  input  logic [W_BITS-1:0] height_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [23:0]       rgb_data_i,
  output logic [7:0]        conv_red_o,
  output logic [7:0]        conv_green_o,
  output logic [7:0]        conv_blue_o,
  output logic              conv_valid_o,
  input  logic [7:0]        conv_gray_i,
  input  logic              conv_done_i,
  output logic [7:0]        pix_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_eol_o,
  output logic              pix_last_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W_BITS-1:0] width_q, height_q;
  logic [W_BITS-1:0] col_q, row_q;
  logic [ADDR_W-1:0] total_q, addr_q;
  logic [1:0]        infl_q, infl_d;
  logic [1:0]        sb1_q, sb2_q;
  logic              cv_q;

  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic rd_en, busy, done;
  logic push, pop, empty;
  logic credit_ok, eol, last, zero_dim;

  assign zero_dim = (width_i == '0) || (height_i == '0);
  assign eol  = col_q == width_q - W_BITS'(1);
  assign last = eol && (row_q == height_q - W_BITS'(1));

  assign empty = cnt_q == '0;
  assign pop   = !empty && pix_ready_i;
  assign push  = conv_done_i && (infl_q != 2'd0);

  // Reserve a FIFO slot for every read still in flight.
  assign credit_ok =
    (SW'(cnt_q) + SW'(infl_q) + SW'(1)) <=
    (SW'(FIFO_DEPTH) + SW'(pop));

  assign infl_d = infl_q + {1'b0, rd_en} - {1'b0, push};
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = zero_dim ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rd_en && (addr_q == total_q - ADDR_W'(1)))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((infl_q == 2'd0) && empty) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    rd_en = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_RUN: begin
        busy  = 1'b1;
        rd_en = credit_ok;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      width_q  <= '0;
      height_q <= '0;
      total_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      infl_q   <= '0;
      sb1_q    <= '0;
      sb2_q    <= '0;
      cv_q     <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start_i) begin
        width_q  <= width_i;
        height_q <= height_i;
        total_q  <= ADDR_W'(width_i) * ADDR_W'(height_i);
        col_q    <= '0;
        row_q    <= '0;
        addr_q   <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (eol) begin
          col_q <= '0;
          row_q <= row_q + W_BITS'(1);
        end else begin
          col_q <= col_q + W_BITS'(1);
        end
      end
      // Flags ride alongside the read so they meet conv_done_i.
      cv_q   <= rd_en;
      sb1_q  <= rd_en ? {last, eol} : 2'b00;
      sb2_q  <= sb1_q;
      infl_q <= infl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {sb2_q, conv_gray_i};
  end

  assign busy_o       = busy;
  assign frame_done_o = done;
  assign rd_en_o      = rd_en;
  assign rd_addr_o    = rd_en ? addr_q : '0;

  assign conv_valid_o = cv_q;
  assign conv_red_o   = cv_q ? rgb_data_i[23:16] : 8'd0;
  assign conv_green_o = cv_q ? rgb_data_i[15:8]  : 8'd0;
  assign conv_blue_o  = cv_q ? rgb_data_i[7:0]   : 8'd0;

  assign pix_valid_o = !empty;
  assign {pix_last_o, pix_eol_o, pix_o} =
    empty ? 10'd0 : mem_q[rptr_q];

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// tb_gray_frame_ctrl: directed checks of raster reads, converter
// handshake, FIFO back-pressure, zero-size frames and reset.
`timescale 1ns/1ps
module tb_gray_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [9:0]  width_i;
  logic [9:0]  height_i;
  logic        busy_o;
  logic        frame_done_o;
  logic        rd_en_o;
  logic [19:0] rd_addr_o;
  logic [23:0] rgb_q;
  logic [7:0]  conv_red_o;
  logic [7:0]  conv_green_o;
  logic [7:0]  conv_blue_o;
  logic        conv_valid_o;
  logic [7:0]  cgray_q;
  logic        cdone_q;
  logic [7:0]  pix_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic        pix_eol_o;
  logic        pix_last_o;

  gray_frame_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .width_i      (width_i),
    .height_i     (height_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rgb_data_i   (rgb_q),
    .conv_red_o   (conv_red_o),
    .conv_green_o (conv_green_o),
    .conv_blue_o  (conv_blue_o),
    .conv_valid_o (conv_valid_o),
    .conv_gray_i  (cgray_q),
    .conv_done_i  (cdone_q),
    .pix_o        (pix_o),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .pix_eol_o    (pix_eol_o),
    .pix_last_o   (pix_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [23:0] c);
    logic [7:0] r, g, b;
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
    return (r >> 2) + (g >> 1) + (g >> 6) +
           (b >> 3) + (b >> 4) + (b >> 5);
  endfunction

  logic [23:0] rgb_mem [256];

  // RGB memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_o) rgb_q <= rgb_mem[int'(rd_addr_o) & 255];
  end

  // Converter: result and done one cycle after its input strobe.
  always @(posedge clk) begin
    cdone_q <= conv_valid_o;
    cgray_q <= gray_of({conv_red_o, conv_green_o, conv_blue_o});
  end

  logic       clr_req;
  int         cyc, n_rd, n_done, n_pv, first_rd, first_pv;
  int         q_addr [$];
  logic [9:0] q_pix [$];
  logic       held_v;
  logic [9:0] held;

  always @(negedge clk) begin
    if (!rst || clr_req) begin
      cyc      <= 0;
      n_rd     <= 0;
      n_done   <= 0;
      n_pv     <= 0;
      first_rd <= -1;
      first_pv <= -1;
      held_v   <= 1'b0;
      q_addr.delete();
      q_pix.delete();
    end else begin
      cyc <= cyc + 1;
      if (rd_en_o) begin
        n_rd <= n_rd + 1;
        q_addr.push_back(int'(rd_addr_o));
        if (first_rd < 0) first_rd <= cyc;
      end
      if (pix_valid_o) begin
        n_pv <= n_pv + 1;
        if (first_pv < 0) first_pv <= cyc;
      end
      if (pix_valid_o && pix_ready_i)
        q_pix.push_back({pix_last_o, pix_eol_o, pix_o});
      if (frame_done_o) n_done <= n_done + 1;
      if (held_v && pix_valid_o)
        chk("hold", 32'({pix_last_o, pix_eol_o, pix_o}), 32'(held));
      held_v <= pix_valid_o && !pix_ready_i;
      held   <= {pix_last_o, pix_eol_o, pix_o};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    step(1);
  endtask

  task automatic start_frame(input int w, input int h);
    width_i  = 10'(w);
    height_i = 10'(h);
    start_i  = 1'b1;
    step(1);
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!frame_done_o && k < lim) begin
      step(1);
      k++;
    end
    chk(tag, 32'(k < lim), 32'd1);
    step(3);
  endtask

  task automatic check_frame(input string tag, input int w, input int h);
    int n;
    logic [9:0] exp;
    n = w * h;
    chk({tag, "_npix"}, 32'(q_pix.size()), 32'(n));
    chk({tag, "_nrd"}, 32'(n_rd), 32'(n));
    chk({tag, "_done"}, 32'(n_done), 32'd1);
    for (int i = 0; i < n && i < q_pix.size(); i++) begin
      exp = {i == n - 1, (i % w) == w - 1, gray_of(rgb_mem[i])};
      chk({tag, "_pix"}, 32'(q_pix[i]), 32'(exp));
    end
    for (int i = 0; i < n && i < q_addr.size(); i++)
      chk({tag, "_addr"}, 32'(q_addr[i]), 32'(i));
  endtask

  task automatic zero_case(input string tag, input int w, input int h);
    int done_at;
    clr();
    width_i  = 10'(w);
    height_i = 10'(h);
    start_i  = 1'b1;
    done_at  = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (frame_done_o && done_at == 0) done_at = k;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    chk({tag, "_cyc"}, 32'(done_at), 32'd2);
    chk({tag, "_nrd"}, 32'(n_rd), 32'd0);
    chk({tag, "_done"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rgb_mem[i] = {8'(i * 37 + 11), 8'(i * 13 + 5), 8'(i * 7 + 3)};
    rgb_mem[0] = 24'hFFFFFF;
    rgb_mem[1] = {8'd100, 8'd50, 8'd20};

    rst = 1'b0;
    clr_req = 1'b0;
    start_i = 1'b0;
    width_i = '0;
    height_i = '0;
    pix_ready_i = 1'b1;
    step(3);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rd", 32'({rd_en_o, rd_addr_o}), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_pix", 32'({pix_valid_o, pix_last_o, pix_eol_o, pix_o}), 32'd0);
    chk("rst_conv", 32'({conv_valid_o, conv_red_o, conv_green_o, conv_blue_o}), 32'd0);
    rst = 1'b1;
    step(2);

    // 4x2 frame, free-running sink
    clr();
    start_frame(4, 2);
    chk("a_busy_run", 32'(busy_o), 32'd1);
    wait_done("a_timeout", 200);
    check_frame("a", 4, 2);
    chk("a_lat", 32'(first_pv - first_rd), 32'd3);
    chk("a_idle", 32'(busy_o), 32'd0);
    if (q_pix.size() >= 8) begin
      chk("a_white", 32'(q_pix[0][7:0]), 32'd246);
      chk("a_rgb", 32'(q_pix[1][7:0]), 32'd53);
      chk("a_eol3", 32'(q_pix[3][9:8]), 32'd1);
      chk("a_last7", 32'(q_pix[7][9:8]), 32'd3);
    end

    // 8x1 frame, sink stalled for 20 cycles
    pix_ready_i = 1'b0;
    clr();
    start_frame(8, 1);
    step(20);
    chk("b_nrd_stall", 32'(n_rd), 32'd4);
    chk("b_npix_stall", 32'(q_pix.size()), 32'd0);
    chk("b_valid", 32'(pix_valid_o), 32'd1);
    chk("b_head", 32'(pix_o), 32'(gray_of(rgb_mem[0])));
    pix_ready_i = 1'b1;
    wait_done("b_timeout", 200);
    check_frame("b", 8, 1);

    zero_case("z_w0", 0, 3);
    zero_case("z_h0", 5, 0);

    // start pulse during RUN must be ignored
    clr();
    start_frame(3, 2);
    step(2);
    width_i  = 10'd7;
    height_i = 10'd5;
    start_i  = 1'b1;
    step(1);
    start_i  = 1'b0;
    wait_done("d_timeout", 200);
    check_frame("d", 3, 2);

    // reset in the middle of a 16x16 frame
    clr();
    start_frame(16, 16);
    step(10);
    chk("e_busy_mid", 32'(busy_o), 32'd1);
    rst = 1'b0;
    step(1);
    chk("e_busy", 32'(busy_o), 32'd0);
    chk("e_rd", 32'({rd_en_o, rd_addr_o}), 32'd0);
    chk("e_done", 32'(frame_done_o), 32'd0);
    chk("e_conv", 32'({conv_valid_o, conv_red_o, conv_green_o, conv_blue_o}), 32'd0);
    chk("e_pix", 32'({pix_valid_o, pix_last_o, pix_eol_o, pix_o}), 32'd0);
    rst = 1'b1;
    clr();
    step(10);
    chk("e_nopv", 32'(n_pv), 32'd0);
    chk("e_nord", 32'(n_rd), 32'd0);
    start_frame(2, 2);
    wait_done("e_timeout", 200);
    check_frame("e", 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_frame_ctrl.md
GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

Interface
REQ-001 SHALL have parameters:
- `W_BITS`, 10: width of the `width_i`, `height_i` and column counters.
- `ADDR_W`, 20: width of the read address.
- `FIFO_DEPTH`, 4: depth of the output FIFO (power of 2, ≥4).

REQ-002 SHALL have ports:
- `clk`  in  1: the single clock; all logic rises on `posedge clk`.
- `rst`  in  1: reset, synchronous and active-low.
- `start_i`  in  1: 1-cycle frame start request.
- `width_i`  in  `W_BITS`: frame width in pixels; sampled at accepted start.
- `height_i`  in  `W_BITS`: frame height in rows; sampled at accepted start.
- `busy_o`  out  1: high from accepted start until `frame_done_o`.
- `frame_done_o`  out  1: 1-cycle pulse at frame end.
- `rd_en_o`  out  1: RGB memory read strobe.
- `rd_addr_o`  out  `ADDR_W`: linear raster pixel address.
- `rgb_data_i`  in  24: {R[23:16], G[15:8], B[7:0]}, valid exactly 1 cycle after `rd_en_o`.
- `conv_red_o`, `conv_green_o`, `conv_blue_o`  out  8 each: to converter `red_i`/`green_i`/`blue_i`.
- `conv_valid_o`  out  1: to converter `done_i`.
- `conv_gray_i`  in  8: from converter `grayscale_o`.
- `conv_done_i`  in  1: from converter `done_o`; 1 cycle after `conv_valid_o`.
- `pix_o`  out  8: grayscale pixel to the Sobel window stage.
- `pix_valid_o`  out  1: `pix_o` holds a valid pixel.
- `pix_ready_i`  in  1: downstream can accept.
- `pix_eol_o`  out  1: qualifies `pix_o` as the last pixel of its row.
- `pix_last_o`  out  1: qualifies `pix_o` as the last pixel of the frame.

Function
REQ-003 SHALL implement the FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: `start_i`=1 accepts the frame. Nonzero `width_i` and `height_i` go to RUN; a zero dimension goes directly to DONE.
- RUN: issue reads until `width*height` reads are issued, then go to DRAIN.
- DRAIN: go to DONE when in-flight=0, the FIFO is empty and no transfer is pending.
- DONE: assert `frame_done_o` for 1 cycle, then IDLE.
REQ-004 SHALL ignore `start_i` outside IDLE; `width_i`/`height_i` changes after acceptance have no effect.
REQ-005 SHALL sequence addresses 0, 1, …, `width*height`-1 in raster order, one per `rd_en_o` cycle; the product is computed at `ADDR_W` bits.
REQ-006 SHALL track column 0..width-1 and row 0..height-1. Column wraps to 0 and row increments after column=width-1. EOL and LAST flags are generated at issue time.
REQ-007 SHALL drive `conv_*_o` from `rgb_data_i` and `conv_valid_o` = `rd_en_o` delayed 1 cycle; channel outputs are 0 when `conv_valid_o`=0.
REQ-008 SHALL carry the EOL/LAST flags through a 2-stage sideband pipe aligned to `conv_done_i`.
REQ-009 SHALL write {LAST, EOL, `conv_gray_i`} into the FIFO in every cycle that `conv_done_i`=1.
REQ-010 SHALL keep an in-flight count (0..2) of reads issued but not yet written to the FIFO.
REQ-011 SHALL assert `rd_en_o` in RUN only when fifo_count + in-flight + 1 ≤ `FIFO_DEPTH`, accounting for a same-cycle pop. The FIFO therefore never overflows.
REQ-012 SHALL present the FIFO head on `pix_o`/`pix_eol_o`/`pix_last_o` with `pix_valid_o`=!empty.
- A pixel transfers when `pix_valid_o` && `pix_ready_i`.
- Outputs hold stable while `pix_valid_o`=1 and `pix_ready_i`=0.
REQ-013 SHALL give a minimum latency of 3 cycles from `rd_en_o` to `pix_valid_o` for that pixel (read 1 + converter 1 + FIFO register 1).
REQ-014 SHALL, with `pix_ready_i` held high, sustain 1 pixel/cycle after the initial latency.
REQ-015 SHALL handle a simultaneous FIFO push and pop in one cycle with fifo_count unchanged; pointers wrap modulo `FIFO_DEPTH`.
REQ-016 SHALL keep `busy_o`=1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-017 SHALL ignore `conv_done_i` pulses that arrive while in-flight=0 (no FIFO write).

Reset
REQ-018 SHALL, on a `clk` edge with `rst`=0, enter IDLE from any state, including mid-frame.
REQ-019 SHALL, on reset, clear all counters, in-flight and FIFO pointers, and the sideband pipe.
REQ-020 SHALL, on reset, force every output to 0: `busy_o`, `frame_done_o`, `rd_en_o`, `rd_addr_o`, `conv_*_o`, `pix_*_o`.
REQ-021 SHALL, after mid-frame reset, produce no `pix_valid_o` until a new accepted start.

Verification
REQ-022 SHALL cover the following directed scenarios:
- 4x2 frame, `pix_ready_i`=1: addresses 0..7 → 8 pixels. `pix_eol_o` is set on pixels 3 and 7, `pix_last_o` on pixel 7. First `pix_valid_o` is 3 cycles after first `rd_en_o`. `frame_done_o` pulses once.
- RGB (255,255,255) → `pix_o`=246; RGB (100,50,20) → `pix_o`=53; both match the converter shift formula.
- 8x1 frame with `pix_ready_i`=0 for 20 cycles: at most 4 `rd_en_o` pulses, no pixels lost. `pix_o` holds stable. Release → all 8 pixels delivered in order.
- `width_i`=0 or `height_i`=0 with `start_i`: no `rd_en_o`. `frame_done_o` pulses 2 cycles after start.
- `start_i` pulsed mid-frame: ignored; pixel count stays `width*height`.
- `rst`=0 during RUN of a 16x16 frame: next cycle all outputs are 0 and the FSM is in IDLE. A new 2x2 frame then completes correctly.
